// File: rtl/decode_issue_stage_pkg.sv
// Shared decode definitions: R-type field layout, funct/ALU codes and the
// instruction decoder used by the issue stage.
package decode_issue_stage_pkg;

    localparam logic [5:0]  OP_RTYPE   = 6'h00;
    localparam logic [5:0]  FUNCT_ADD  = 6'h20;
    localparam logic [5:0]  FUNCT_SUB  = 6'h22;
    localparam logic [5:0]  FUNCT_AND  = 6'h24;
    localparam logic [5:0]  FUNCT_OR   = 6'h25;
    localparam logic [5:0]  FUNCT_SLT  = 6'h2A;
    localparam logic [31:0] NOP_WORD   = 32'h0;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        alu_t       aluop;
        logic       illegal;
    } dec_t;

    // The all-zero word has funct 0, so it is matched before the funct table.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.rs      = w[25:21];
        d.rt      = w[20:16];
        d.rd      = w[15:11];
        d.aluop   = ALU_AND;
        d.illegal = 1'b0;
        if (w == NOP_WORD) begin
            d.aluop = ALU_ADD;
        end else if (w[31:26] != OP_RTYPE) begin
            d.illegal = 1'b1;
        end else begin
            case (w[5:0])
                FUNCT_ADD: d.aluop = ALU_ADD;
                FUNCT_SUB: d.aluop = ALU_SUB;
                FUNCT_AND: d.aluop = ALU_AND;
                FUNCT_OR:  d.aluop = ALU_OR;
                FUNCT_SLT: d.aluop = ALU_SLT;
                default:   d.illegal = 1'b1;
            endcase
        end
        if (d.illegal) d.rd = '0;
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// Per-register busy bits for in-flight results; flags a RAW hazard on either
// source unless the same-cycle writeback is retiring that register.
module reg_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              haz
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy;

    function automatic logic pending(input logic [ADDR_W-1:0] a);
        return busy[a] && (a != '0) && !(clr_en && clr_addr == a);
    endfunction

    assign haz = pending(rd_addr1) || pending(rd_addr2);

    // Set is applied after clear so a same-register set/clear leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: drives reg_bank read/write ports, bypasses same-cycle
// writeback into the operands and holds the ID/EX register under backpressure.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Instr_in,
    input  logic              Instr_valid,
    output logic              Instr_ready,
    output logic [ADDR_W-1:0] AR1,
    output logic [ADDR_W-1:0] AR2,
    input  logic [DATA_W-1:0] DR1,
    input  logic [DATA_W-1:0] DR2,
    input  logic              WB_valid,
    input  logic [ADDR_W-1:0] WB_addr,
    input  logic [DATA_W-1:0] WB_data,
    output logic [ADDR_W-1:0] Awrite,
    output logic [DATA_W-1:0] DataIn,
    output logic              WReg,
    output logic              EX_valid,
    input  logic              EX_ready,
    output logic [DATA_W-1:0] EX_opA,
    output logic [DATA_W-1:0] EX_opB,
    output logic [ADDR_W-1:0] EX_rd,
    output logic [2:0]        EX_aluop,
    output logic              EX_illegal
);
    dec_t              dec;
    logic              haz;
    logic              fire;
    logic              set_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign dec     = decode(Instr_in);
    assign AR1     = ADDR_W'(dec.rs);
    assign AR2     = ADDR_W'(dec.rt);
    assign rd_addr = ADDR_W'(dec.rd);

    assign Awrite = WB_addr;
    assign DataIn = WB_data;
    assign WReg   = WB_valid && (WB_addr != '0);

    assign Instr_ready = (!EX_valid || EX_ready) && !haz;
    assign fire        = Instr_valid && Instr_ready;
    assign set_en      = fire && !dec.illegal && (rd_addr != '0);

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (rd_addr),
        .clr_en   (WB_valid),
        .clr_addr (WB_addr),
        .rd_addr1 (AR1),
        .rd_addr2 (AR2),
        .haz      (haz)
    );

    function automatic logic [DATA_W-1:0] sel_op(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] bank);
        if (a == '0)                      return '0;
        else if (WB_valid && WB_addr == a) return WB_data;
        else                               return bank;
    endfunction

    assign op_a = sel_op(AR1, DR1);
    assign op_b = sel_op(AR2, DR2);

    always_ff @(posedge clk) begin
        if (rst) begin
            EX_valid   <= 1'b0;
            EX_opA     <= '0;
            EX_opB     <= '0;
            EX_rd      <= '0;
            EX_aluop   <= '0;
            EX_illegal <= 1'b0;
        end else if (fire) begin
            EX_valid   <= 1'b1;
            EX_opA     <= op_a;
            EX_opB     <= op_b;
            EX_rd      <= rd_addr;
            EX_aluop   <= dec.aluop;
            EX_illegal <= dec.illegal;
        end else if (EX_ready) begin
            EX_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage with a behavioural reg_bank model.
module tb_decode_issue_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr_in;
    logic        Instr_valid;
    logic        Instr_ready;
    logic [4:0]  AR1, AR2, WB_addr, Awrite, EX_rd;
    logic [31:0] DR1, DR2, WB_data, DataIn, EX_opA, EX_opB;
    logic        WB_valid, WReg, EX_valid, EX_ready, EX_illegal;
    logic [2:0]  EX_aluop;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    decode_issue_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .Instr_in(Instr_in), .Instr_valid(Instr_valid),
        .Instr_ready(Instr_ready), .AR1(AR1), .AR2(AR2), .DR1(DR1), .DR2(DR2),
        .WB_valid(WB_valid), .WB_addr(WB_addr), .WB_data(WB_data),
        .Awrite(Awrite), .DataIn(DataIn), .WReg(WReg),
        .EX_valid(EX_valid), .EX_ready(EX_ready), .EX_opA(EX_opA), .EX_opB(EX_opB),
        .EX_rd(EX_rd), .EX_aluop(EX_aluop), .EX_illegal(EX_illegal)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 9)  return 32'd358;
        if (i == 15) return 32'd7;
        return 32'(100 + i);
    endfunction

    // reg_bank model: async read, write on WReg
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
        end else if (WReg) begin
            regs[Awrite] <= DataIn;
        end
    end
    assign DR1 = regs[AR1];
    assign DR2 = regs[AR2];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [4:0]  rd;
        logic [2:0]  aluop;
        logic        illegal;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{rtype(9, 15, 3, 6'h20),  32'd358, 32'd7,   5'd3, 3'b010, 1'b0};
        tbl[1] = '{rtype(1, 2, 5, 6'h22),   32'd101, 32'd102, 5'd5, 3'b110, 1'b0};
        tbl[2] = '{rtype(0, 20, 6, 6'h24),  32'd0,   32'd120, 5'd6, 3'b000, 1'b0};
        tbl[3] = '{rtype(31, 0, 7, 6'h25),  32'd131, 32'd0,   5'd7, 3'b001, 1'b0};
        tbl[4] = '{rtype(1, 2, 9, 6'h3F),   32'd101, 32'd102, 5'd0, 3'b000, 1'b1};
        tbl[5] = '{{6'h23, 5'd1, 5'd2, 5'd10, 5'd0, 6'h20}, 32'd101, 32'd102, 5'd0, 3'b000, 1'b1};
        tbl[6] = '{rtype(10, 11, 8, 6'h2A), 32'd110, 32'd111, 5'd8, 3'b111, 1'b0};
        tbl[7] = '{32'h0,                   32'd0,   32'd0,   5'd0, 3'b010, 1'b0};
        tbl[8] = '{rtype(9, 9, 0, 6'h20),   32'd358, 32'd358, 5'd0, 3'b010, 1'b0};

        rst = 1'b1; Instr_in = '0; Instr_valid = 1'b0; EX_ready = 1'b1;
        WB_valid = 1'b0; WB_addr = '0; WB_data = '0;
        step(); step();
        chk("reset EX_valid", 32'(EX_valid), 32'd0);
        chk("reset EX_opA", EX_opA, 32'd0);
        chk("reset EX_rd", 32'(EX_rd), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset Instr_ready", 32'(Instr_ready), 32'd1);

        // single-issue vectors; each followed by a writeback retiring its rd
        for (int i = 0; i < 9; i++) begin
            Instr_in = tbl[i].instr; Instr_valid = 1'b1;
            #1;
            chk($sformatf("v%0d ready", i), 32'(Instr_ready), 32'd1);
            step();
            chk($sformatf("v%0d EX_valid", i), 32'(EX_valid), 32'd1);
            chk($sformatf("v%0d opA", i), EX_opA, tbl[i].opa);
            chk($sformatf("v%0d opB", i), EX_opB, tbl[i].opb);
            chk($sformatf("v%0d rd", i), 32'(EX_rd), 32'(tbl[i].rd));
            chk($sformatf("v%0d aluop", i), 32'(EX_aluop), 32'(tbl[i].aluop));
            chk($sformatf("v%0d illegal", i), 32'(EX_illegal), 32'(tbl[i].illegal));
            Instr_valid = 1'b0;
            WB_valid = (tbl[i].rd != 0); WB_addr = tbl[i].rd; WB_data = 32'(100 + int'(tbl[i].rd));
            step();
            WB_valid = 1'b0;
            chk($sformatf("v%0d drained", i), 32'(EX_valid), 32'd0);
        end

        // RAW stall until writeback, then bypass
        Instr_in = rtype(1, 2, 4, 6'h20); Instr_valid = 1'b1;
        step();
        Instr_in = rtype(4, 2, 5, 6'h22);
        #1;
        chk("raw stall", 32'(Instr_ready), 32'd0);
        step();
        chk("raw stall 2", 32'(Instr_ready), 32'd0);
        chk("raw EX drained", 32'(EX_valid), 32'd0);
        WB_valid = 1'b1; WB_addr = 5'd4; WB_data = 32'd99;
        #1;
        chk("raw release", 32'(Instr_ready), 32'd1);
        step();
        chk("bypass opA", EX_opA, 32'd99);
        chk("bypass opB", EX_opB, 32'd102);
        chk("bypass aluop", 32'(EX_aluop), 32'b110);
        WB_valid = 1'b0;
        Instr_in = rtype(4, 0, 0, 6'h20);
        #1;
        chk("busy4 cleared", 32'(Instr_ready), 32'd1);
        step();
        chk("r4 written", EX_opA, 32'd99);
        Instr_valid = 1'b0; WB_valid = 1'b1; WB_addr = 5'd5; WB_data = 32'd105;
        step();
        WB_valid = 1'b0;

        // backpressure holds ID/EX
        EX_ready = 1'b0;
        Instr_in = rtype(9, 15, 0, 6'h20); Instr_valid = 1'b1;
        step();
        chk("bp EX_valid", 32'(EX_valid), 32'd1);
        Instr_in = rtype(1, 2, 0, 6'h25);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp ready c%0d", c), 32'(Instr_ready), 32'd0);
            step();
            chk($sformatf("bp hold opA c%0d", c), EX_opA, 32'd358);
            chk($sformatf("bp hold valid c%0d", c), 32'(EX_valid), 32'd1);
        end
        EX_ready = 1'b1;
        #1;
        chk("bp release", 32'(Instr_ready), 32'd1);
        step();
        chk("bp next opA", EX_opA, 32'd101);
        chk("bp next aluop", 32'(EX_aluop), 32'b001);
        Instr_valid = 1'b0;
        step();

        // WB to r0 never writes; rs=0 reads as zero
        WB_valid = 1'b1; WB_addr = 5'd0; WB_data = 32'd5;
        Instr_in = rtype(0, 15, 0, 6'h24); Instr_valid = 1'b1;
        #1;
        chk("r0 WReg", 32'(WReg), 32'd0);
        chk("r0 DataIn", DataIn, 32'd5);
        step();
        chk("r0 opA", EX_opA, 32'd0);
        chk("r0 opB", EX_opB, 32'd7);
        WB_valid = 1'b0; Instr_valid = 1'b0;
        step();

        // reset mid-flight drops ID/EX and busy bits
        EX_ready = 1'b0;
        Instr_in = rtype(1, 2, 3, 6'h20); Instr_valid = 1'b1;
        step();
        chk("pre-rst EX_valid", 32'(EX_valid), 32'd1);
        Instr_in = rtype(3, 0, 0, 6'h20); Instr_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst EX_valid", 32'(EX_valid), 32'd0);
        chk("rst EX_opA", EX_opA, 32'd0);
        chk("rst EX_rd", 32'(EX_rd), 32'd0);
        #1;
        chk("rst busy cleared", 32'(Instr_ready), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
